spi_frame_master: RTL and testbench

//  SPI mode-0 master that drives the MOSI/SCK/SS link into fpwm's SPI receiver.

---
 rtl/spi_frame_master.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_frame_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) frame master.
// Takes bytes from a valid/ready stream with an end-of-frame tag and shifts
// them out LSB first, keeping SS low from the first bit to the last bit of a
// frame. A one-byte hold register lets the next byte be queued while the
// current one is being shifted, so consecutive bytes go out with a continuous
// SCK. If the next byte is late, SCK parks low with SS still asserted.

module spi_frame_master #(
    parameter int unsigned CLK_DIV  = 10,
    parameter int unsigned SS_SETUP = 10,
    parameter int unsigned SS_HOLD  = 10,
    parameter int unsigned SS_GAP   = 20
) (
    input  logic       i_Clk,
    input  logic       i_Resetn,
    input  logic [7:0] i_Data,
    input  logic       i_Last,
    input  logic       i_Valid,
    output logic       o_Ready,
    output logic       o_MOSI,
    output logic       o_SCK,
    output logic       o_SS,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BIT_W   = $clog2(DATA_W);
    localparam int unsigned MAX_A   = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int unsigned MAX_B   = (SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(SS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(SS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shifter;
    logic                cur_last;
    logic                stall;

    logic [DATA_W-1:0]   hold_data;
    logic                hold_last;
    logic                hold_full;

    logic                rst_meta_n;
    logic                rst_sync_n;

    logic                accept_c;
    logic                cnt_end_c;
    logic                load_c;

    // Reset synchroniser: assertion is immediate, release aligned to i_Clk.
    always_ff @(posedge i_Clk or negedge i_Resetn) begin
        if (!i_Resetn) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    // Handshake, phase-counter terminal count and shifter-load decode.
    always_comb begin
        accept_c  = i_Valid & o_Ready;
        cnt_end_c = 1'b0;
        load_c    = 1'b0;
        case (state)
            SETUP:    cnt_end_c = (cnt == SETUP_END);
            LOW:      cnt_end_c = (cnt == DIV_END);
            HIGH:     cnt_end_c = (cnt == DIV_END);
            HOLD:     cnt_end_c = (cnt == HOLD_END);
            GAP:      cnt_end_c = (cnt == GAP_END);
            default:  cnt_end_c = 1'b0;
        endcase
        case (state)
            IDLE:     load_c = hold_full;
            LOW:      load_c = stall & hold_full;
            HIGH:     load_c = cnt_end_c & (bit_cnt == BIT_LAST) & ~cur_last & hold_full;
            default:  load_c = 1'b0;
        endcase
    end

    // One-byte hold register; a same-cycle accept and load leaves it full.
    always_ff @(posedge i_Clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            o_Ready   <= 1'b1;
        end else begin
            if (accept_c) begin
                hold_data <= i_Data;
                hold_last <= i_Last;
                hold_full <= 1'b1;
            end else if (load_c) begin
                hold_full <= 1'b0;
            end
            o_Ready <= ~(accept_c | (hold_full & ~load_c));
        end
    end

    // Frame sequencer: SS setup, SCK low/high phases, underrun stall, SS hold and gap.
    always_ff @(posedge i_Clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            cur_last <= 1'b0;
            stall    <= 1'b0;
            o_SS     <= 1'b1;
            o_SCK    <= 1'b0;
            o_MOSI   <= 1'b0;
            o_Busy   <= 1'b0;
            o_Done   <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shifter  <= hold_data;
                        cur_last <= hold_last;
                        o_SS     <= 1'b0;
                        o_Busy   <= 1'b1;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt_end_c) begin
                        o_MOSI  <= shifter[0];
                        bit_cnt <= '0;
                        cnt     <= '0;
                        state   <= LOW;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                LOW: begin
                    if (stall) begin
                        // Parked between bytes: counter frozen until a byte arrives.
                        if (hold_full) begin
                            shifter  <= hold_data;
                            cur_last <= hold_last;
                            o_MOSI   <= hold_data[0];
                            bit_cnt  <= '0;
                            cnt      <= '0;
                            stall    <= 1'b0;
                        end
                    end else if (cnt_end_c) begin
                        o_SCK <= 1'b1;
                        cnt   <= '0;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                HIGH: begin
                    if (cnt_end_c) begin
                        o_SCK <= 1'b0;
                        cnt   <= '0;
                        if (bit_cnt != BIT_LAST) begin
                            shifter <= {1'b0, shifter[DATA_W-1:1]};
                            o_MOSI  <= shifter[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            state   <= LOW;
                        end else if (cur_last) begin
                            state <= HOLD;
                        end else if (hold_full) begin
                            shifter  <= hold_data;
                            cur_last <= hold_last;
                            o_MOSI   <= hold_data[0];
                            bit_cnt  <= '0;
                            state    <= LOW;
                        end else begin
                            stall <= 1'b1;
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (cnt_end_c) begin
                        o_SS   <= 1'b1;
                        o_Done <= 1'b1;
                        cnt    <= '0;
                        state  <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt_end_c) begin
                        o_Busy <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a line monitor rebuilds bytes from MOSI at
// each SCK rise and compares them with a queue of bytes the driver accepted.
`timescale 1ns/1ps

module tb_spi_frame_master;

    localparam int unsigned CLK_DIV  = 10;
    localparam int unsigned SS_SETUP = 10;
    localparam int unsigned SS_HOLD  = 10;
    localparam int unsigned SS_GAP   = 20;
    localparam time         T_CLK    = 10ns;
    localparam time         T_SCK    = 2 * CLK_DIV * T_CLK;
    localparam int          TIMEOUT  = 20000;

    logic       i_Clk = 1'b0;
    logic       i_Resetn;
    logic [7:0] i_Data;
    logic       i_Last;
    logic       i_Valid;
    logic       o_Ready;
    logic       o_MOSI;
    logic       o_SCK;
    logic       o_SS;
    logic       o_Busy;
    logic       o_Done;

    spi_frame_master #(
        .CLK_DIV (CLK_DIV),
        .SS_SETUP(SS_SETUP),
        .SS_HOLD (SS_HOLD),
        .SS_GAP  (SS_GAP)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Resetn(i_Resetn),
        .i_Data  (i_Data),
        .i_Last  (i_Last),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .o_MOSI  (o_MOSI),
        .o_SCK   (o_SCK),
        .o_SS    (o_SS),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done)
    );

    always #(T_CLK / 2) i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line monitor statistics (written only by the monitor).
    logic prev_sck  = 1'b0;
    logic prev_ss   = 1'b1;
    logic prev_mosi = 1'b0;
    logic [7:0] acc = '0;
    int   nbits       = 0;
    int   rise_cnt    = 0;
    int   fall_cnt    = 0;
    int   done_cnt    = 0;
    int   per_ok      = 0;
    int   per_bad     = 0;
    int   bad_edge    = 0;
    int   mosi_glitch = 0;
    int   ss_low_run  = 0;
    int   ss_low_len  = 0;
    int   ss_high_run = 0;
    int   gap_len     = 0;
    time  last_rise   = 0;

    // Sample the link on the falling clock edge, away from output updates.
    always @(negedge i_Clk) begin
        logic [7:0] exp_b;
        if (o_SCK && !prev_sck) begin
            rise_cnt++;
            if (o_SS) bad_edge++;
            if (last_rise != 0) begin
                if ($time - last_rise == T_SCK) per_ok++;
                else per_bad++;
            end
            last_rise = $time;
            acc = {o_MOSI, acc[7:1]};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_byte", 32'(acc), 32'hFFFF_FFFF);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("mosi_byte", 32'(acc), 32'(exp_b));
                end
            end
        end
        if (o_SS) begin
            nbits     = 0;
            last_rise = 0;
        end
        if (o_SCK && prev_sck && (o_MOSI != prev_mosi)) mosi_glitch++;
        if (!o_SS && prev_ss) begin
            fall_cnt++;
            gap_len     = ss_high_run;
            ss_high_run = 0;
        end
        if (o_SS && !prev_ss) begin
            ss_low_len = ss_low_run;
            ss_low_run = 0;
        end
        if (!o_SS) ss_low_run++;
        else ss_high_run++;
        if (o_Done) done_cnt++;
        prev_sck  = o_SCK;
        prev_ss   = o_SS;
        prev_mosi = o_MOSI;
    end

    task automatic idle_bus();
        i_Valid = 1'b0;
        i_Data  = 8'($urandom);
        i_Last  = 1'($urandom);
    endtask

    // Present one byte and hold it until the handshake completes.
    task automatic send_byte(input logic [7:0] data, input logic last);
        logic rdy;
        bit   ok = 1'b0;
        @(negedge i_Clk);
        i_Valid = 1'b1;
        i_Data  = data;
        i_Last  = last;
        for (int i = 0; i < TIMEOUT; i++) begin
            rdy = o_Ready;
            @(posedge i_Clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_Clk);
        end
        if (ok) sb_q.push_back(data);
        else check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int base, input int n);
        bit ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge i_Clk);
            if (done_cnt - base >= n && !o_Busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ss"},    32'(o_SS),    32'd1);
        check({pfx, "_sck"},   32'(o_SCK),   32'd0);
        check({pfx, "_mosi"},  32'(o_MOSI),  32'd0);
        check({pfx, "_ready"}, 32'(o_Ready), 32'd1);
        check({pfx, "_busy"},  32'(o_Busy),  32'd0);
        check({pfx, "_done"},  32'(o_Done),  32'd0);
    endtask

    initial begin
        int b_rise, b_fall, b_done, b_ok, b_bad, b_edge, b_gl;
        logic [7:0] t1[5];
        bit ok;
        t1[0] = 8'h12; t1[1] = 8'h34; t1[2] = 8'h56; t1[3] = 8'h78; t1[4] = 8'h11;

        i_Resetn = 1'b0;
        idle_bus();
        repeat (3) @(negedge i_Clk);
        check_reset_outputs("rst");
        i_Resetn = 1'b1;

        // Idle with garbage on the data lines and valid low: nothing happens.
        for (int i = 0; i < 20; i++) begin
            @(negedge i_Clk);
            idle_bus();
        end
        check("idle_busy", 32'(o_Busy), 32'd0);
        check("idle_ss", 32'(o_SS), 32'd1);
        check("idle_rises", 32'(rise_cnt), 32'd0);

        // T1: five-byte streamed frame.
        b_rise = rise_cnt; b_fall = fall_cnt; b_done = done_cnt;
        b_ok = per_ok; b_bad = per_bad; b_edge = bad_edge; b_gl = mosi_glitch;
        for (int i = 0; i < 5; i++) send_byte(t1[i], i == 4);
        @(negedge i_Clk);
        idle_bus();
        wait_done(b_done, 1);
        check("t1_rises", 32'(rise_cnt - b_rise), 32'd40);
        check("t1_ss_windows", 32'(fall_cnt - b_fall), 32'd1);
        check("t1_done", 32'(done_cnt - b_done), 32'd1);
        check("t1_period_ok", 32'(per_ok - b_ok), 32'd39);
        check("t1_period_bad", 32'(per_bad - b_bad), 32'd0);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // T2: single byte; SS low for setup + 8 bits + hold.
        b_rise = rise_cnt; b_done = done_cnt;
        send_byte(8'hA5, 1'b1);
        @(negedge i_Clk);
        idle_bus();
        wait_done(b_done, 1);
        check("t2_rises", 32'(rise_cnt - b_rise), 32'd8);
        check("t2_ss_low", 32'(ss_low_len), 32'(SS_SETUP + 16 * CLK_DIV + SS_HOLD));
        check("t2_done", 32'(done_cnt - b_done), 32'd1);

        // T3: underrun between bytes of one frame.
        b_rise = rise_cnt; b_fall = fall_cnt; b_done = done_cnt;
        send_byte(8'h3C, 1'b0);
        @(negedge i_Clk);
        idle_bus();
        repeat (500) @(negedge i_Clk);
        check("t3_stall_rises", 32'(rise_cnt - b_rise), 32'd8);
        check("t3_stall_sck", 32'(o_SCK), 32'd0);
        check("t3_stall_ss", 32'(o_SS), 32'd0);
        check("t3_stall_busy", 32'(o_Busy), 32'd1);
        send_byte(8'hC3, 1'b1);
        @(negedge i_Clk);
        idle_bus();
        wait_done(b_done, 1);
        check("t3_rises", 32'(rise_cnt - b_rise), 32'd16);
        check("t3_ss_windows", 32'(fall_cnt - b_fall), 32'd1);
        check("t3_done", 32'(done_cnt - b_done), 32'd1);

        // T4: two one-byte frames back to back.
        b_fall = fall_cnt; b_done = done_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        @(negedge i_Clk);
        idle_bus();
        wait_done(b_done, 2);
        check("t4_ss_windows", 32'(fall_cnt - b_fall), 32'd2);
        check("t4_done", 32'(done_cnt - b_done), 32'd2);
        check("t4_gap_min", 32'(gap_len >= int'(SS_GAP)), 32'd1);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // T5: reset in the middle of bit 4.
        b_rise = rise_cnt;
        send_byte(8'h5A, 1'b0);
        @(negedge i_Clk);
        idle_bus();
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge i_Clk);
            if (rise_cnt - b_rise >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("t5_rise_timeout", 32'd0, 32'd1);
        repeat (CLK_DIV + CLK_DIV / 2) @(negedge i_Clk);
        check("t5_mid_bit_sck", 32'(o_SCK), 32'd0);
        #3;
        i_Resetn = 1'b0;
        #1;
        check_reset_outputs("t5");
        sb_q.delete();
        @(negedge i_Clk);
        i_Resetn = 1'b1;
        repeat (100) @(negedge i_Clk);
        check("t5_rises_after", 32'(rise_cnt - b_rise), 32'd4);
        check("t5_ready", 32'(o_Ready), 32'd1);
        check("t5_busy", 32'(o_Busy), 32'd0);

        // Recovery frame after the reset.
        b_rise = rise_cnt; b_done = done_cnt;
        send_byte(8'h7E, 1'b1);
        @(negedge i_Clk);
        idle_bus();
        wait_done(b_done, 1);
        check("rec_rises", 32'(rise_cnt - b_rise), 32'd8);
        check("rec_sb_empty", 32'(sb_q.size()), 32'd0);

        // Line-level invariants over the whole run.
        check("sck_outside_ss", 32'(bad_edge), 32'd0);
        check("mosi_change_sck_high", 32'(mosi_glitch), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
